// File: rtl/data_mem_responder.sv
// data_mem_responder: single-outstanding 64-bit word memory with fixed access latency.
// Optional DMEM_ACCESS_COUNT_EN adds committed load/store counters (rd_count, wr_count).
module data_mem_responder #(
   parameter int DEPTH       = 128,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [63:0] req_addr,
   input  logic [63:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [63:0] rsp_rdata,
   output logic        rsp_error
`ifdef DMEM_ACCESS_COUNT_EN
   ,
   output logic [31:0] rd_count,
   output logic [31:0] wr_count
`endif
);
   localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2;
   logic [1:0]  state;
   logic [3:0]  cnt;
   logic        lat_write;
   logic [63:0] lat_addr, lat_wdata;
   logic [63:0] mem [DEPTH];
   logic        accept, go_resp, acc_write, acc_err;
   logic [63:0] acc_addr, acc_wdata;
   logic [AW-1:0] idx;
   assign req_ready = reset_n && state == IDLE;
   assign accept    = req_valid && req_ready;
   // with zero wait the access happens on the accept edge, so use the live request
   assign acc_write = state == IDLE ? req_write : lat_write;
   assign acc_addr  = state == IDLE ? req_addr  : lat_addr;
   assign acc_wdata = state == IDLE ? req_wdata : lat_wdata;
   assign acc_err   = acc_addr >= 64'(DEPTH);
   assign idx       = acc_addr[AW-1:0];
   assign go_resp   = (accept && WAIT_CYCLES == 0) || (state == WAIT && cnt == 4'd0);
   // request FSM and response registers
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         lat_write <= 1'b0;
         lat_addr  <= 64'd0;
         lat_wdata <= 64'd0;
         rsp_valid <= 1'b0;
         rsp_rdata <= 64'd0;
         rsp_error <= 1'b0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               lat_write <= req_write;
               lat_addr  <= req_addr;
               lat_wdata <= req_wdata;
               if (WAIT_CYCLES == 0) state <= RESP;
               else begin
                  state <= WAIT;
                  cnt   <= 4'(WAIT_CYCLES - 1);
               end
            end
            WAIT: if (cnt != 4'd0) cnt <= cnt - 4'd1;
                  else state <= RESP;
            RESP: if (rsp_ready) begin
               state     <= IDLE;
               rsp_valid <= 1'b0;
               rsp_rdata <= 64'd0;
               rsp_error <= 1'b0;
            end
            default: state <= IDLE;
         endcase
         if (go_resp) begin
            rsp_valid <= 1'b1;
            rsp_error <= acc_err;
            rsp_rdata <= (acc_write || acc_err) ? 64'd0 : mem[idx];
         end
      end
   end
   // storage array; never reset, stores commit only when in range
   always_ff @(posedge clock) begin
      if (go_resp && acc_write && !acc_err) mem[idx] <= acc_wdata;
   end
`ifdef DMEM_ACCESS_COUNT_EN
   // committed access counters, errors excluded, wrap naturally
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rd_count <= 32'd0;
         wr_count <= 32'd0;
      end else if (go_resp && !acc_err) begin
         if (acc_write) wr_count <= wr_count + 32'd1;
         else rd_count <= rd_count + 32'd1;
      end
   end
`endif
endmodule
